// File: rtl/chan_sched_pkg.sv
// Shared constants and types for the round-robin channel scheduler.
package chan_sched_pkg;

  localparam int NUM_CH = 6;
  localparam int DW     = 4;
  localparam int SEL_W  = 3;

  typedef enum logic {IDLE, PRESENT} state_t;
  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping modulo NUM_CH.
module rr_pick
  import chan_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  sel_t              ptr,
  output logic              found,
  output sel_t              idx
);

  int   j;
  sel_t jj;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_CH) j = j - NUM_CH;
      jj = sel_t'(j);
      if (!found && req[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/chan_rr_sched.sv
// Six-channel round-robin scheduler driving a 6:1 data selector with a valid/ready output.
// Optional saturating stall counter enabled by defining CHSCHED_STALL_CNT_EN.
//
// state   | meaning
// IDLE    | nothing presented, arbitrate every cycle
// PRESENT | hold[sel] offered downstream, re-arbitrate on handshake
module chan_rr_sched
  import chan_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_CH-1:0]    in_valid,
  input  logic [NUM_CH*DW-1:0] in_data,
  output logic [NUM_CH-1:0]    in_ready,
  output logic [DW-1:0]        data0,
  output logic [DW-1:0]        data1,
  output logic [DW-1:0]        data2,
  output logic [DW-1:0]        data3,
  output logic [DW-1:0]        data4,
  output logic [DW-1:0]        data5,
  output logic [SEL_W-1:0]     sel,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef CHSCHED_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  logic [NUM_CH-1:0] full;
  logic [DW-1:0]     hold [NUM_CH];
  state_t            state;
  sel_t              ptr;

  logic              handshake;
  logic [NUM_CH-1:0] consume_mask;
  logic [NUM_CH-1:0] cand;
  logic              found;
  sel_t              pick;

  assign in_ready     = ~full;
  assign handshake    = out_valid && out_ready;
  assign consume_mask = handshake ? ({{(NUM_CH-1){1'b0}}, 1'b1} << sel) : '0;
  // Registered full bits only, so a word loaded this cycle competes from the next cycle on.
  assign cand         = full & ~consume_mask;

  assign data0 = hold[0];
  assign data1 = hold[1];
  assign data2 = hold[2];
  assign data3 = hold[3];
  assign data4 = hold[4];
  assign data5 = hold[5];

  rr_pick u_pick (
    .req   (cand),
    .ptr   (ptr),
    .found (found),
    .idx   (pick)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      full <= '0;
      for (int i = 0; i < NUM_CH; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (in_valid[i] && !full[i]) hold[i] <= in_data[i*DW +: DW];
      end
      full <= (full & ~consume_mask) | (in_valid & ~full);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      sel       <= '0;
      ptr       <= sel_t'(NUM_CH - 1);
    end else if (state == IDLE || handshake) begin
      if (found) begin
        state     <= PRESENT;
        out_valid <= 1'b1;
        sel       <= pick;
        ptr       <= pick;
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CHSCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_chan_rr_sched.sv
// Self-checking bench for chan_rr_sched: directed vector table plus a randomised scoreboard run.
module tb_chan_rr_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  in_valid;
  logic [23:0] in_data;
  logic [5:0]  in_ready;
  logic [3:0]  data0, data1, data2, data3, data4, data5;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
`ifdef CHSCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  chan_rr_sched dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .data0     (data0),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .data4     (data4),
    .data5     (data5),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef CHSCHED_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic [5:0]  iv;
    logic [23:0] id;
    logic        ordy;
    logic        eov;
    logic [2:0]  esel;
    logic [5:0]  erdy;
    logic [23:0] edata;
    logic [15:0] estall;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rstn, input logic [5:0] iv, input logic [23:0] id, input logic ordy,
                     input logic eov, input logic [2:0] esel, input logic [5:0] erdy,
                     input logic [23:0] edata, input logic [15:0] estall);
    vec_t v;
    v.rstn = rstn; v.iv = iv; v.id = id; v.ordy = ordy;
    v.eov = eov; v.esel = esel; v.erdy = erdy; v.edata = edata; v.estall = estall;
    vecs.push_back(v);
  endtask

  function automatic logic [3:0] data_at(input logic [2:0] idx);
    case (idx)
      3'd0:    return data0;
      3'd1:    return data1;
      3'd2:    return data2;
      3'd3:    return data3;
      3'd4:    return data4;
      default: return data5;
    endcase
  endfunction

  logic [3:0] q[6][$];
  int         waits[6];
  int         max_wait;
  int         delivered;

  initial begin
    resetn = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;

    // Single load on channel 2: one idle cycle, then presented, then consumed.
    add(0, 6'h00, 24'h000000, 0,  0, 3'd0, 6'h3F, 24'h000000, 16'd0);
    add(1, 6'h04, 24'h000A00, 1,  0, 3'd0, 6'h3B, 24'h000A00, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  1, 3'd2, 6'h3B, 24'h000A00, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  0, 3'd2, 6'h3F, 24'h000A00, 16'd0);
    // All six loaded at once, drained back-to-back in order 0..5.
    add(0, 6'h00, 24'h000000, 1,  0, 3'd0, 6'h3F, 24'h000000, 16'd0);
    add(1, 6'h3F, 24'h654321, 1,  0, 3'd0, 6'h00, 24'h654321, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  1, 3'd0, 6'h00, 24'h654321, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  1, 3'd1, 6'h01, 24'h654321, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  1, 3'd2, 6'h03, 24'h654321, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  1, 3'd3, 6'h07, 24'h654321, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  1, 3'd4, 6'h0F, 24'h654321, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  1, 3'd5, 6'h1F, 24'h654321, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  0, 3'd5, 6'h3F, 24'h654321, 16'd0);
    // Channels 1 and 4; channel 1 refilled right after its grant, 4 wins before 1 again.
    add(1, 6'h12, 24'h090070, 0,  0, 3'd5, 6'h2D, 24'h694371, 16'd0);
    add(1, 6'h00, 24'h000000, 0,  1, 3'd1, 6'h2D, 24'h694371, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  1, 3'd4, 6'h2F, 24'h694371, 16'd0);
    add(1, 6'h02, 24'h000080, 1,  0, 3'd4, 6'h3D, 24'h694381, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  1, 3'd1, 6'h3D, 24'h694381, 16'd0);
    add(1, 6'h00, 24'h000000, 1,  0, 3'd1, 6'h3F, 24'h694381, 16'd0);
    // Channel 3 presented and stalled for five cycles.
    add(1, 6'h08, 24'h00C000, 0,  0, 3'd1, 6'h37, 24'h69C381, 16'd0);
    add(1, 6'h00, 24'h000000, 0,  1, 3'd3, 6'h37, 24'h69C381, 16'd0);
    add(1, 6'h00, 24'h000000, 0,  1, 3'd3, 6'h37, 24'h69C381, 16'd1);
    add(1, 6'h00, 24'h000000, 0,  1, 3'd3, 6'h37, 24'h69C381, 16'd2);
    add(1, 6'h00, 24'h000000, 0,  1, 3'd3, 6'h37, 24'h69C381, 16'd3);
    add(1, 6'h00, 24'h000000, 0,  1, 3'd3, 6'h37, 24'h69C381, 16'd4);
    add(1, 6'h00, 24'h000000, 0,  1, 3'd3, 6'h37, 24'h69C381, 16'd5);
    // Load 0 and 5 while still presenting, then reset mid-operation.
    add(1, 6'h21, 24'hF0000E, 0,  1, 3'd3, 6'h16, 24'hF9C38E, 16'd6);
    add(0, 6'h00, 24'h000000, 0,  0, 3'd0, 6'h3F, 24'h000000, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      resetn    = vecs[i].rstn;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      out_ready = vecs[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].eov));
      chk($sformatf("v%0d sel", i),       32'(sel),       32'(vecs[i].esel));
      chk($sformatf("v%0d in_ready", i),  32'(in_ready),  32'(vecs[i].erdy));
      chk($sformatf("v%0d data", i), 32'({data5, data4, data3, data2, data1, data0}), 32'(vecs[i].edata));
`ifdef CHSCHED_STALL_CNT_EN
      chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(vecs[i].estall));
`endif
    end

    // Randomised traffic against a per-channel word queue.
    max_wait = 0;
    delivered = 0;
    for (int i = 0; i < 6; i++) waits[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      resetn    = 1'b1;
      in_valid  = 6'($urandom);
      in_data   = 24'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        chk("rand sel range", 32'(sel < 3'd6), 32'd1);
        if (sel < 3'd6) begin
          if (q[sel].size() == 0) begin
            chk("rand delivered without load", 32'(q[sel].size()), 32'd1);
          end else begin
            chk($sformatf("rand data ch%0d", sel), 32'(data_at(sel)), 32'(q[sel][0]));
            void'(q[sel].pop_front());
          end
          for (int i = 0; i < 6; i++) begin
            if (i != int'(sel) && !in_ready[i]) begin
              waits[i]++;
              if (waits[i] > max_wait) max_wait = waits[i];
            end
          end
          waits[sel] = 0;
        end
        delivered++;
      end
      for (int i = 0; i < 6; i++) begin
        if (in_valid[i] && in_ready[i]) q[i].push_back(in_data[i*4 +: 4]);
      end
    end
    @(negedge clk);
    in_valid = '0;
    out_ready = 1'b0;
    #1;
    chk("rand fairness max wait ok", 32'(max_wait <= 5), 32'd1);
    chk("rand some words delivered", 32'(delivered > 200), 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rand pending ch%0d", i), 32'(q[i].size()), 32'(!in_ready[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
